// File: rtl/sort_frame_loader.sv
// sort_frame_loader
//
// Upstream feeder for the 8-entry byte sorter. Packs a valid/ready byte
// stream into frames of FRAME_LEN slots, holds the frame stable on the
// sorter inputs, waits LATENCY cycles for the sorter pipeline to reflect
// it, then raises frame_valid until the consumer acknowledges.
//
// Optional feature (compile-time macro SORT_LOADER_PAD_EN):
//   a byte accepted with s_last=1 closes a short frame; the remaining
//   slots are zero-filled and frame_len reports the real byte count.
//   Without the macro s_last is ignored and frames are always full.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   s_data/s_valid/s_ready/s_last   input byte stream (valid/ready)
//   frm1..frm8         frame slots, wired to sorter inputs in1..in8
//   frame_valid        sorter outputs hold the sorted held frame
//   frame_ack          consumer has taken the sorted frame (HOLD only)
//   frame_len          real bytes in the held frame (1..8, 0 after reset)
//   frame_cnt          frames acknowledged since reset, wraps at 256

module sort_frame_loader #(
  parameter int LATENCY   = 2,
  parameter int FRAME_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       s_last,
  output logic [7:0] frm1,
  output logic [7:0] frm2,
  output logic [7:0] frm3,
  output logic [7:0] frm4,
  output logic [7:0] frm5,
  output logic [7:0] frm6,
  output logic [7:0] frm7,
  output logic [7:0] frm8,
  output logic       frame_valid,
  input  logic       frame_ack,
  output logic [3:0] frame_len,
  output logic [7:0] frame_cnt
);

  localparam int IW = $clog2(FRAME_LEN);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] LAT_LOAD = CW'(LATENCY);

  typedef enum logic [1:0] {
    FILL,
    SETTLE,
    HOLD
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx;
  logic [CW-1:0] settle_cnt;
  logic [7:0]    slot [FRAME_LEN];

  logic accept;
  logic close_frame;
  logic short_last;

`ifdef SORT_LOADER_PAD_EN
  assign short_last = s_last;
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign short_last    = 1'b0;
`endif

  // Pure state decode; gating with rst keeps the stream stalled while
  // reset is held, independent of s_valid.
  assign s_ready     = (state == FILL) && !rst;
  assign frame_valid = (state == HOLD);
  assign accept      = s_valid && s_ready;

  // Next-state logic.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first,
    // so no path through the case can leave it unassigned (no latch).
    state_nxt   = state;
    close_frame = 1'b0;
    unique case (state)
      FILL: begin
        if (accept && (idx == LAST_IDX || short_last)) begin
          close_frame = 1'b1;
          state_nxt   = SETTLE;
        end
      end
      SETTLE: begin
        // Counter loaded at the closing edge; HOLD is entered on the
        // edge where it runs out, LATENCY edges after the last write.
        if (settle_cnt <= CW'(1)) state_nxt = HOLD;
      end
      HOLD: begin
        if (frame_ack) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      settle_cnt <= '0;
      frame_len  <= '0;
      frame_cnt  <= '0;
      // NOTE: the slot array is reset explicitly because its contents
      // drive the sorter and must read 0x00 after reset; it is a small
      // register file, not a RAM, so a reset costs nothing unusual.
      for (int i = 0; i < FRAME_LEN; i++) slot[i] <= 8'h00;
    end else begin
      if (accept) begin
        slot[idx] <= s_data;
        if (close_frame) begin
          idx        <= '0;
          frame_len  <= 4'(idx) + 4'd1;
          settle_cnt <= LAT_LOAD;
`ifdef SORT_LOADER_PAD_EN
          // Zero the unfilled tail; zeros sort to the end of the
          // descending output.
          for (int i = 0; i < FRAME_LEN; i++) begin
            if (i > int'(idx)) slot[i] <= 8'h00;
          end
`endif
        end else begin
          idx <= idx + IW'(1);
        end
      end

      if (state == SETTLE && settle_cnt != '0) settle_cnt <= settle_cnt - CW'(1);

      if (state == HOLD && frame_ack) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  assign frm1 = slot[0];
  assign frm2 = slot[1];
  assign frm3 = slot[2];
  assign frm4 = slot[3];
  assign frm5 = slot[4];
  assign frm6 = slot[5];
  assign frm7 = slot[6];
  assign frm8 = slot[7];

endmodule

// File: tb/tb_sort_frame_loader.sv
// Testbench for sort_frame_loader: directed scenarios plus a randomized
// stream, all checked every cycle against a transaction-level model
// (queue of received bytes + edges elapsed since the frame closed).

module tb_sort_frame_loader;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       s_last;
  logic [7:0] frm1, frm2, frm3, frm4, frm5, frm6, frm7, frm8;
  logic       frame_valid;
  logic       frame_ack;
  logic [3:0] frame_len;
  logic [7:0] frame_cnt;

  sort_frame_loader #(.LATENCY(LAT), .FRAME_LEN(8)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .frm1(frm1), .frm2(frm2), .frm3(frm3), .frm4(frm4),
    .frm5(frm5), .frm6(frm6), .frm7(frm7), .frm8(frm8),
    .frame_valid(frame_valid), .frame_ack(frame_ack),
    .frame_len(frame_len), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  bit         m_closed;
  int         m_age;
  logic [7:0] m_cur [$];
  logic [7:0] m_slot [8];
  int         m_len;
  int         m_cnt;

  function automatic logic [7:0] get_frm(input int i);
    case (i)
      0: return frm1;  1: return frm2;  2: return frm3;  3: return frm4;
      4: return frm5;  5: return frm6;  6: return frm7;  default: return frm8;
    endcase
  endfunction

  task automatic model_reset();
    m_closed = 1'b0;
    m_age    = 0;
    m_cur.delete();
    for (int i = 0; i < 8; i++) m_slot[i] = 8'h00;
    m_len = 0;
    m_cnt = 0;
  endtask

  task automatic model_close();
    m_closed = 1'b1;
    m_age    = 0;
    m_len    = m_cur.size();
  endtask

  task automatic compare_all(input string ctx);
    check({ctx, ".s_ready"},     32'(s_ready),     32'(!m_closed));
    check({ctx, ".frame_valid"}, 32'(frame_valid), 32'(m_closed && m_age >= LAT));
    check({ctx, ".frame_cnt"},   32'(frame_cnt),   32'(m_cnt));
    check({ctx, ".frame_len"},   32'(frame_len),   32'(m_len));
    for (int i = 0; i < 8; i++)
      check($sformatf("%s.frm%0d", ctx, i + 1), 32'(get_frm(i)), 32'(m_slot[i]));
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare.
  task automatic cycle(input string ctx, input bit v, input logic [7:0] d,
                       input bit a, input bit l);
    s_valid   = v;
    s_data    = d;
    frame_ack = a;
    s_last    = l;
    @(posedge clk);
    if (!m_closed) begin
      if (v) begin
        m_slot[m_cur.size()] = d;
        m_cur.push_back(d);
        if (m_cur.size() == 8) model_close();
`ifdef SORT_LOADER_PAD_EN
        else if (l) begin
          for (int i = m_cur.size(); i < 8; i++) m_slot[i] = 8'h00;
          model_close();
        end
`endif
      end
    end else if (m_age >= LAT) begin
      if (a) begin
        m_closed = 1'b0;
        m_cnt    = (m_cnt + 1) % 256;
        m_cur.delete();
      end
    end else begin
      m_age++;
    end
    #1;
    compare_all(ctx);
  endtask

  task automatic do_reset(input string ctx);
    rst = 1'b1;
    #1;
    model_reset();
    check({ctx, ".rst_s_ready"},     32'(s_ready),     32'd0);
    check({ctx, ".rst_frame_valid"}, 32'(frame_valid), 32'd0);
    check({ctx, ".rst_frame_len"},   32'(frame_len),   32'd0);
    check({ctx, ".rst_frame_cnt"},   32'(frame_cnt),   32'd0);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s.rst_frm%0d", ctx, i + 1), 32'(get_frm(i)), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check({ctx, ".post_rst_s_ready"}, 32'(s_ready), 32'd1);
  endtask

  // Sort the observed frame the way the sorter does (descending) and
  // compare against an expected sorted byte list.
  task automatic check_sorted(input string ctx, input logic [7:0] exp [8]);
    logic [7:0] s [8];
    logic [7:0] t;
    for (int i = 0; i < 8; i++) s[i] = get_frm(i);
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7 - i; j++)
        if (s[j] < s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    for (int i = 0; i < 8; i++)
      check($sformatf("%s.sorted%0d", ctx, i), 32'(s[i]), 32'(exp[i]));
  endtask

  logic [7:0] full_bytes [8] = '{8'h05, 8'h11, 8'h03, 8'hF0, 8'h00, 8'h7A, 8'h7A, 8'h22};
  logic [7:0] full_sort  [8] = '{8'hF0, 8'h7A, 8'h7A, 8'h22, 8'h11, 8'h05, 8'h03, 8'h00};
  logic [7:0] pad_sort   [8] = '{8'h30, 8'h20, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  initial begin
    rst = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; frame_ack = 1'b0;
    model_reset();
    #2;
    do_reset("init");

    // Full frame, back-to-back.
    for (int i = 0; i < 8; i++) cycle("full", 1'b1, full_bytes[i], 1'b0, 1'b0);
    cycle("settle", 1'b0, 8'h00, 1'b0, 1'b0);
    check("settle.valid_low", 32'(frame_valid), 32'd0);
    cycle("settle", 1'b0, 8'h00, 1'b0, 1'b0);
    check("hold.valid_high", 32'(frame_valid), 32'd1);
    check_sorted("full", full_sort);

    // Backpressure in HOLD, then ack together with s_valid.
    for (int i = 0; i < 5; i++) cycle("bp", 1'b1, 8'hAA, 1'b0, 1'b0);
    cycle("bp_ack", 1'b1, 8'hAA, 1'b1, 1'b0);
    check("bp_ack.frm1_kept", 32'(frm1), 32'h05);
    cycle("bp_next", 1'b1, 8'hAA, 1'b0, 1'b0);
    check("bp_next.frm1_aa", 32'(frm1), 32'hAA);
    // Finish that frame, then ack it.
    for (int i = 0; i < 7; i++) cycle("bp_fill", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < LAT; i++) cycle("bp_settle", 1'b0, 8'h00, 1'b0, 1'b0);
    cycle("bp_ack2", 1'b0, 8'h00, 1'b1, 1'b0);

    // Gapped stream: alternating s_valid over 16 cycles.
    for (int i = 0; i < 16; i++) cycle("gap", (i % 2) == 0, 8'(8'h80 + i), 1'b0, 1'b0);
    check("gap.closed", 32'(s_ready), 32'd0);
    for (int i = 0; i < LAT; i++) cycle("gap_settle", 1'b0, 8'h00, 1'b0, 1'b0);
    cycle("gap_ack", 1'b0, 8'h00, 1'b1, 1'b0);

    // Reset mid-fill after 5 bytes, then a fresh frame 0x01..0x08.
    for (int i = 0; i < 5; i++) cycle("mid", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    do_reset("midrst");
    for (int i = 0; i < 8; i++) cycle("fresh", 1'b1, 8'(i + 1), 1'b0, 1'b0);
    for (int i = 0; i < LAT; i++) cycle("fresh_settle", 1'b0, 8'h00, 1'b0, 1'b0);
    check("fresh.frm1", 32'(frm1), 32'h01);
    check("fresh.len", 32'(frame_len), 32'd8);
    cycle("fresh_ack", 1'b0, 8'h00, 1'b1, 1'b0);

    // Short frame with s_last.
    cycle("pad", 1'b1, 8'h10, 1'b0, 1'b0);
    cycle("pad", 1'b1, 8'h30, 1'b0, 1'b0);
    cycle("pad", 1'b1, 8'h20, 1'b0, 1'b1);
`ifdef SORT_LOADER_PAD_EN
    for (int i = 0; i < LAT; i++) cycle("pad_settle", 1'b0, 8'h00, 1'b0, 1'b0);
    check("pad.len", 32'(frame_len), 32'd3);
    check_sorted("pad", pad_sort);
    cycle("pad_ack", 1'b0, 8'h00, 1'b1, 1'b0);
`else
    cycle("nopad_idle", 1'b0, 8'h00, 1'b0, 1'b0);
    check("nopad.s_ready", 32'(s_ready), 32'd1);
    check("nopad.valid", 32'(frame_valid), 32'd0);
    for (int i = 0; i < 5; i++) cycle("nopad_fill", 1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < LAT; i++) cycle("nopad_settle", 1'b0, 8'h00, 1'b0, 1'b0);
    cycle("nopad_ack", 1'b0, 8'h00, 1'b1, 1'b0);
`endif

    // Randomized stream with random acks and s_last.
    for (int i = 0; i < 1500; i++)
      cycle("rand", $urandom_range(3, 0) != 0, 8'($urandom()),
            $urandom_range(4, 0) < 2, $urandom_range(4, 0) == 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
